// File: rtl/audio_out_stage_pkg.sv
// Shared types, constants and saturation helpers for the audio output stage.
package msx_audio_pkg;

  typedef logic signed [15:0] audio_sample_t;

  typedef enum logic [1:0] {
    IDLE,
    PROC_L,
    PROC_R,
    OUT
  } audio_fsm_t;

  localparam int AUDIO_MAX = 32767;
  localparam int AUDIO_MIN = -32768;

  // DC-block output / feedback state is two bits wider than a sample so a
  // full-scale step (65535) survives the filter before volume is applied.
  localparam int Y_WIDTH = 18;
  localparam int Y_MAX   = 131071;
  localparam int Y_MIN   = -131072;

  typedef logic signed [Y_WIDTH-1:0] dc_state_t;

  // Result of one pass through the shared channel datapath.
  typedef struct packed {
    audio_sample_t sample;
    logic          clip;
    dc_state_t     y_state;
  } chain_out_t;

  function automatic logic fits16(input logic signed [23:0] v);
    return (v <= 24'(AUDIO_MAX)) && (v >= 24'(AUDIO_MIN));
  endfunction

  function automatic audio_sample_t sat16(input logic signed [23:0] v);
    if (v > 24'(AUDIO_MAX)) return audio_sample_t'(AUDIO_MAX);
    if (v < 24'(AUDIO_MIN)) return audio_sample_t'(AUDIO_MIN);
    return v[15:0];
  endfunction

  function automatic dc_state_t sat18(input logic signed [19:0] v);
    if (v > 20'(Y_MAX)) return dc_state_t'(Y_MAX);
    if (v < 20'(Y_MIN)) return dc_state_t'(Y_MIN);
    return v[Y_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/audio_out_stage_if.sv
// Registered stereo sample stream from the output stage to the audio sink.
interface audio_out_stage_if;
  import msx_audio_pkg::*;

  audio_sample_t audio_L;
  audio_sample_t audio_R;
  logic          sample_valid;

  modport master (output audio_L, audio_R, sample_valid);
  modport slave  (input  audio_L, audio_R, sample_valid);
endinterface

// File: rtl/audio_out_stage_chain.sv
// Combinational DC-block + volume + saturate datapath, shared by both
// channels; the caller supplies the filter state of the channel in flight.
module audio_chain_slice
  import msx_audio_pkg::*;
#(
  parameter int DC_SHIFT = 8
) (
  input  audio_sample_t x,
  input  audio_sample_t x_prev,
  input  dc_state_t     y_prev,
  input  logic          dc_en,
  input  logic [3:0]    volume,
  input  logic          mute,
  output chain_out_t    res
);

  logic signed [19:0] dc_sum;
  dc_state_t          y;
  logic [4:0]         gain;
  logic signed [23:0] prod;
  logic signed [23:0] scaled;

  always_comb begin
    // Leaky differentiator: pole at 1 - 2^-DC_SHIFT.
    dc_sum = 20'(x) - 20'(x_prev) + 20'(y_prev) - 20'(y_prev >>> DC_SHIFT);
    y      = dc_en ? sat18(dc_sum) : Y_WIDTH'(x);

    gain   = {1'b0, volume} + 5'd1;
    prod   = 24'(y) * $signed({19'd0, gain});
    scaled = prod >>> 4;

    // With the filter bypassed its feedback restarts from zero.
    res.y_state = dc_en ? y : '0;
    res.sample  = mute ? '0 : sat16(scaled);
    res.clip    = !mute && !fits16(scaled);
  end

endmodule

// File: rtl/audio_out_stage.sv
// Boxcar decimator feeding a time-shared DC-block/volume chain; presents a
// registered stereo sample with a one-cycle valid strobe and sticky clip flags.
module audio_out_stage
  import msx_audio_pkg::*;
#(
  parameter int DIV_LOG2 = 9,
  parameter int DC_SHIFT = 8
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  audio_sample_t             sound_L,
  input  audio_sample_t             sound_R,
  input  logic                      dc_block_en,
  input  logic [3:0]                volume,
  input  logic                      mute,
  input  logic                      clip_clr,
  output logic                      clip_L,
  output logic                      clip_R,
  audio_out_stage_if.master         audio_out
);

  localparam int ACC_W = 16 + DIV_LOG2;
  typedef logic signed [ACC_W-1:0] acc_t;

  logic [DIV_LOG2-1:0] cnt;
  logic                wrap;
  acc_t                acc_L, acc_R;
  acc_t                sum_L, sum_R;

  audio_sample_t       x_L, x_R;
  audio_sample_t       x_prev_L, x_prev_R;
  dc_state_t           y_prev_L, y_prev_R;

  audio_fsm_t          state, state_next;

  // Controls captured in PROC_L so both channels of one sample agree.
  logic                dc_en_q;
  logic                mute_q;
  logic [3:0]          volume_q;

  audio_sample_t       res_L;
  logic                clip_pend_L;

  audio_sample_t       sl_x, sl_x_prev;
  dc_state_t           sl_y_prev;
  logic                sl_dc_en, sl_mute;
  logic [3:0]          sl_volume;
  chain_out_t          sl_res;

  assign wrap  = (cnt == '1);
  assign sum_L = acc_L + ACC_W'(sound_L);
  assign sum_R = acc_R + ACC_W'(sound_R);

  // Decimation: the wrap cycle's own input is folded into the average.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cnt   <= '0;
      acc_L <= '0;
      acc_R <= '0;
      x_L   <= '0;
      x_R   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt <= cnt + DIV_LOG2'(1);
      if (wrap) begin
        acc_L <= '0;
        acc_R <= '0;
        x_L   <= audio_sample_t'(sum_L >>> DIV_LOG2);
        x_R   <= audio_sample_t'(sum_R >>> DIV_LOG2);
      end else begin
        acc_L <= sum_L;
        acc_R <= sum_R;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_next = state;
    sl_x       = x_L;
    sl_x_prev  = x_prev_L;
    sl_y_prev  = y_prev_L;
    sl_dc_en   = dc_block_en;
    sl_volume  = volume;
    sl_mute    = mute;

    unique case (state)
      IDLE:   if (wrap) state_next = PROC_L;
      PROC_L: state_next = PROC_R;
      PROC_R: begin
        state_next = OUT;
        sl_x       = x_R;
        sl_x_prev  = x_prev_R;
        sl_y_prev  = y_prev_R;
        sl_dc_en   = dc_en_q;
        sl_volume  = volume_q;
        sl_mute    = mute_q;
      end
      OUT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  audio_chain_slice #(.DC_SHIFT(DC_SHIFT)) u_chain (
    .x      (sl_x),
    .x_prev (sl_x_prev),
    .y_prev (sl_y_prev),
    .dc_en  (sl_dc_en),
    .volume (sl_volume),
    .mute   (sl_mute),
    .res    (sl_res)
  );

  // Outputs are loaded on the PROC_R->OUT edge so they are live during OUT.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state                  <= IDLE;
      x_prev_L               <= '0;
      x_prev_R               <= '0;
      y_prev_L               <= '0;
      y_prev_R               <= '0;
      dc_en_q                <= 1'b0;
      mute_q                 <= 1'b0;
      volume_q               <= '0;
      res_L                  <= '0;
      clip_pend_L            <= 1'b0;
      clip_L                 <= 1'b0;
      clip_R                 <= 1'b0;
      audio_out.audio_L      <= '0;
      audio_out.audio_R      <= '0;
      audio_out.sample_valid <= 1'b0;
    end else begin
      state                  <= state_next;
      audio_out.sample_valid <= 1'b0;

      if (clip_clr) begin
        clip_L <= 1'b0;
        clip_R <= 1'b0;
      end

      unique case (state)
        PROC_L: begin
          dc_en_q     <= dc_block_en;
          mute_q      <= mute;
          volume_q    <= volume;
          x_prev_L    <= x_L;
          y_prev_L    <= sl_res.y_state;
          res_L       <= sl_res.sample;
          clip_pend_L <= sl_res.clip;
        end
        PROC_R: begin
          x_prev_R               <= x_R;
          y_prev_R               <= sl_res.y_state;
          audio_out.audio_L      <= res_L;
          audio_out.audio_R      <= sl_res.sample;
          audio_out.sample_valid <= 1'b1;
          // Placed after the clear so a simultaneous new clip wins.
          if (clip_pend_L) clip_L <= 1'b1;
          if (sl_res.clip) clip_R <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
